// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Bundle of the pipeline writeback, multi-cycle result and
//               register-file write port signals seen by writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if;

    // In-order pipeline writeback request
    logic        PIPE_WB_VALID;
    logic [4:0]  PIPE_WB_ADDR;
    logic [31:0] PIPE_WB_DATA;
    logic        PIPE_STALL;

    // Multi-cycle unit: issue notification and late result
    logic        ASYNC_ISSUE_VALID;
    logic [4:0]  ASYNC_ISSUE_ADDR;
    logic        ASYNC_VALID;
    logic [4:0]  ASYNC_ADDR;
    logic [31:0] ASYNC_DATA;
    logic        ASYNC_READY;

    // Register file write port and hazard scoreboard
    logic        WRITE_EN;
    logic [4:0]  IN_ADDRESS;
    logic [31:0] DATA_IN;
    logic [31:0] BUSY_MASK;

    // Arbiter side
    modport slave (
        input  PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
        input  ASYNC_ISSUE_VALID, ASYNC_ISSUE_ADDR,
        input  ASYNC_VALID, ASYNC_ADDR, ASYNC_DATA,
        output PIPE_STALL, ASYNC_READY,
        output WRITE_EN, IN_ADDRESS, DATA_IN, BUSY_MASK
    );

    // Pipeline / multi-cycle unit / register file side
    modport master (
        output PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
        output ASYNC_ISSUE_VALID, ASYNC_ISSUE_ADDR,
        output ASYNC_VALID, ASYNC_ADDR, ASYNC_DATA,
        input  PIPE_STALL, ASYNC_READY,
        input  WRITE_EN, IN_ADDRESS, DATA_IN, BUSY_MASK
    );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Owns the register file write port. Merges the in-order
//               pipeline writeback with buffered multi-cycle results, keeps a
//               busy scoreboard of outstanding multi-cycle destinations, and
//               stalls the pipeline when a buffered result has waited too long.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input wire                  CLK,
    input wire                  RESET,
    writeback_arbiter_if.slave  bus
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);

    // Result buffer storage and pointers (extra MSB distinguishes full/empty)
    logic [4:0]         r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;

    // Cycles the current head has been passed over in favour of the pipeline
    logic [c_cnt_w-1:0] r_starve_cnt;

    // Registered write port and scoreboard
    logic               r_write_en;
    logic [4:0]         r_in_address;
    logic [31:0]        r_data_in;
    logic [31:0]        r_busy_mask;

    logic               w_empty;
    logic               w_full;
    logic               w_ready;
    logic               w_push;
    logic               w_pipe_live;
    logic               w_stall;
    logic               w_drain;
    logic               w_pipe_sel;
    logic [4:0]         w_head_addr;
    logic [31:0]        w_head_data;
    logic [31:0]        w_set_mask;
    logic [31:0]        w_clr_mask;
    logic [c_ptr_w:0]   w_ptr_one;

    assign w_ptr_one   = {{c_ptr_w{1'b0}}, 1'b1};

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                         (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_ready     = !RESET && !w_full;

    // Results for x0 are accepted from the source but never buffered
    assign w_push      = bus.ASYNC_VALID && w_ready && (bus.ASYNC_ADDR != 5'd0);

    // Pipe writes to x0 are discarded and treated as an idle slot
    assign w_pipe_live = bus.PIPE_WB_VALID && (bus.PIPE_WB_ADDR != 5'd0);

    // Starvation forces a head drain; the counter never passes the limit
    // because reaching it with a non-empty buffer always drains the head
    assign w_stall     = (r_starve_cnt >= c_cnt_w'(STARVE_LIMIT)) && !w_empty;

    // Priority: forced drain, then live pipe request, then opportunistic drain
    assign w_drain     = !w_empty && (w_stall || !w_pipe_live);
    assign w_pipe_sel  = w_pipe_live && !w_stall;

    assign w_head_addr = r_fifo_addr[r_rd_ptr[c_ptr_w-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[c_ptr_w-1:0]];

    // The head address is never 0 since x0 results are not buffered
    assign w_set_mask  = (bus.ASYNC_ISSUE_VALID && (bus.ASYNC_ISSUE_ADDR != 5'd0)) ?
                         (32'd1 << bus.ASYNC_ISSUE_ADDR) : 32'd0;
    assign w_clr_mask  = w_drain ? (32'd1 << w_head_addr) : 32'd0;

    // Buffer storage: contents are don't-care once the pointers are cleared
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[c_ptr_w-1:0]] <= bus.ASYNC_ADDR;
            r_fifo_data[r_wr_ptr[c_ptr_w-1:0]] <= bus.ASYNC_DATA;
        end
    end

    // Buffer pointers: push at the tail, drain from the head
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + w_ptr_one;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + w_ptr_one;
            end
        end
    end

    // Starvation counter: counts cycles a present head loses to the pipeline
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_starve_cnt <= '0;
        end else if (w_drain || w_empty) begin
            r_starve_cnt <= '0;
        end else if (w_pipe_sel) begin
            r_starve_cnt <= r_starve_cnt + {{(c_cnt_w-1){1'b0}}, 1'b1};
        end
    end

    // Register file write port: address/data hold when nothing is selected
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_write_en   <= 1'b0;
            r_in_address <= 5'd0;
            r_data_in    <= 32'd0;
        end else begin
            r_write_en <= w_drain || w_pipe_sel;
            if (w_drain) begin
                r_in_address <= w_head_addr;
                r_data_in    <= w_head_data;
            end else if (w_pipe_sel) begin
                r_in_address <= bus.PIPE_WB_ADDR;
                r_data_in    <= bus.PIPE_WB_DATA;
            end
        end
    end

    // Busy scoreboard: a same-cycle issue to a draining register keeps it set
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_busy_mask <= 32'd0;
        end else begin
            r_busy_mask <= (r_busy_mask & ~w_clr_mask) | w_set_mask;
        end
    end

    assign bus.PIPE_STALL  = !RESET && w_stall;
    assign bus.ASYNC_READY = w_ready;
    assign bus.WRITE_EN    = r_write_en;
    assign bus.IN_ADDRESS  = r_in_address;
    assign bus.DATA_IN     = r_data_in;
    assign bus.BUSY_MASK   = r_busy_mask;

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sits directly upstream of the processor register file; owns its single write port (WRITE_EN / IN_ADDRESS / DATA_IN).
- Merges two writeback sources:
  - the in-order MEM/WB pipeline stage, one request per cycle;
  - the late-completing multi-cycle unit (divider / NoC load responses) through a small buffer.
- Keeps a 32-bit scoreboard of registers with outstanding multi-cycle writes for the hazard unit, and throttles the pipeline when buffered results starve.

Parameters:
- FIFO_DEPTH, 4, async result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 8, cycles a FIFO head may wait before the pipeline is stalled for it (>=1)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- PIPE_WB_VALID  in  1  pipeline writeback request
- PIPE_WB_ADDR  in  5  pipeline destination register
- PIPE_WB_DATA  in  32  pipeline result
- PIPE_STALL  out  1  pipeline must hold its WB inputs this cycle
- ASYNC_ISSUE_VALID  in  1  multi-cycle op issued this cycle
- ASYNC_ISSUE_ADDR  in  5  destination of issued op
- ASYNC_VALID  in  1  multi-cycle result valid
- ASYNC_ADDR  in  5  result destination register
- ASYNC_DATA  in  32  result data
- ASYNC_READY  out  1  buffer can accept a result
- WRITE_EN  out  1  register file write enable (registered)
- IN_ADDRESS  out  5  register file write address (registered)
- DATA_IN  out  32  register file write data (registered)
- BUSY_MASK  out  32  bit i = register i has an outstanding async write

Behaviour:
- Clocking and reset: one clock CLK. RESET is synchronous, active-high; at a RESET edge everything clears:
  - WRITE_EN, IN_ADDRESS, DATA_IN = 0; BUSY_MASK = 0;
  - FIFO empty, pointers 0, starvation counter 0.
  - PIPE_STALL = 0 and ASYNC_READY = 0 while RESET is high.
  - Any in-flight or buffered results are discarded.
- Handshakes:
  - ASYNC_READY = !RESET && FIFO not full (combinational from state).
  - An async result is accepted on a cycle with ASYNC_VALID && ASYNC_READY.
  - Accepted results with ASYNC_ADDR==0 are dropped, not enqueued; all others are pushed to the FIFO tail.
- Head eligibility: a FIFO head becomes eligible the cycle after it is pushed. There is no bypass; the minimum async latency is acceptance in cycle N -> WRITE_EN in cycle N+2.
- Pipe request: "live" means PIPE_WB_VALID && PIPE_WB_ADDR!=0. Pipe writes to x0 are discarded and count as idle.
- Per-cycle selection, evaluated in this order:
  1. PIPE_STALL=1 (counter >= STARVE_LIMIT and FIFO non-empty): drain the head. Pipe inputs are ignored; the pipeline re-presents them next cycle.
  2. Pipe live: write the pipe request. The head waits and the counter increments if the FIFO is non-empty.
  3. FIFO non-empty: drain the head.
  4. Otherwise: no write.
- Counter: resets to 0 on every head drain and holds at 0 while the FIFO is empty.
- Output latency: the selected request is registered.
  - WRITE_EN/IN_ADDRESS/DATA_IN are valid in the cycle after selection; the register file commits at the end of that cycle.
  - A pipe request in cycle N gives WRITE_EN=1 in N+1.
  - WRITE_EN=0 whenever nothing was selected; DATA_IN/IN_ADDRESS hold their last values.
- Scoreboard (BUSY_MASK):
  - ASYNC_ISSUE_VALID with addr!=0 sets the bit.
  - A head drain clears the bit of its address in the same edge that registers WRITE_EN.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Preconditions (checked by bench assertions, not by RTL):
  - no issue to a register whose BUSY bit is set;
  - the pipeline never writes a register whose BUSY bit is set.
- Simultaneous push and drain with the FIFO full: ASYNC_READY is 0 that cycle, so there is no push.
- Simultaneous push and drain otherwise: both happen, and occupancy is unchanged.
- Pointer wrap-around: pointers are modulo FIFO_DEPTH with an extra wrap bit for full/empty detection.

Test Plan:
- Reset, then pipe valid addr 5 data 0xDEADBEEF in cycle N -> WRITE_EN=1, IN_ADDRESS=5, DATA_IN=0xDEADBEEF in N+1 only; all outputs 0 during RESET.
- Issue addr 7 -> BUSY_MASK[7]=1 next cycle; async result addr 7 data 0x12 accepted in cycle M with pipe idle -> WRITE_EN with IN_ADDRESS=7, DATA_IN=0x12 in M+2, and BUSY_MASK[7]=0 in that same cycle.
- STARVE_LIMIT=4, pipe live every cycle, one async result buffered -> PIPE_STALL=1 exactly once after 4 waiting cycles; the head is written next cycle, and the pipe data held during the stall is written the cycle after.
- Pipe live continuously, 5 async results offered with FIFO_DEPTH=4 and STARVE_LIMIT=8 -> ASYNC_READY=0 after 4 accepts, the 5th is held by the source and accepted after the first drain, and all 5 are written in order.
- Async result and pipe request both addressed to x0 -> no WRITE_EN, FIFO stays empty, ASYNC_READY stays 1.
- Three results buffered, then RESET for one cycle -> FIFO empty, BUSY_MASK=0, no further WRITE_EN; a new pipe write to addr 3 after reset completes normally.
